// File: rtl/gio_pkg.sv
// Shared constants for the GPIO bank: register offsets within the 64-byte window,
// the window size, the edge-detect arm count and the byte-strobe expansion helper.
package gio_pkg;

    localparam logic [5:0] GIO_OUT      = 6'h00;
    localparam logic [5:0] GIO_DIR      = 6'h04;
    localparam logic [5:0] GIO_IN       = 6'h08;
    localparam logic [5:0] GIO_IRQ_EN   = 6'h0C;
    localparam logic [5:0] GIO_IRQ_STAT = 6'h10;
    localparam logic [5:0] GIO_EDGE     = 6'h14;
    localparam logic [5:0] GIO_SET      = 6'h18;
    localparam logic [5:0] GIO_CLR      = 6'h1C;
    localparam logic [5:0] GIO_TGL      = 6'h20;

    localparam logic [31:0] GIO_WINDOW  = 32'd64;
    localparam logic [1:0]  GIO_ARM_CNT = 2'd3;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gio_sync.sv
// Pad input synchroniser with edge detection; edges are suppressed until the arm
// counter has run for GIO_ARM_CNT cycles after reset so pins high at reset stay quiet.
module gio_sync
    import gio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] in_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [1:0]       arm_q, arm_d;
    logic             armed;

    assign armed = (arm_q == GIO_ARM_CNT);
    assign arm_d = armed ? arm_q : arm_q + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            arm_q <= '0;
        end else begin
            s1_q  <= pad_i;
            s2_q  <= s1_q;
            arm_q <= arm_d;
        end
    end

    // Edges are taken from the values s2 and its history flop are about to load,
    // so the status bit lands on the same edge that makes the pin readable in IN.
    assign in_o   = s2_q;
    assign rise_o = armed ? (s1_q & ~s2_q) : '0;
    assign fall_o = armed ? (~s1_q & s2_q) : '0;

endmodule

// File: rtl/gio_bank.sv
// Memory-mapped GPIO bank on the picoRV32 native bus: direction, synchronised input,
// set/clear/toggle aliases and edge interrupts with write-1-to-clear status.
module gio_bank
    import gio_pkg::*;
#(
    parameter logic [31:0] ADDR  = 32'h0100_0000,
    parameter int          WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [31:0] WIN_MASK = ~(GIO_WINDOW - 32'd1);

    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [WIDTH-1:0] stat_q, stat_d, edge_q, edge_d;
    logic             ready_q;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] pin_s, rise, fall, evt, clr, wm, wd_m;
    logic             sel, acc, wr;
    logic [5:0]       off;

    gio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pad_i  (gpio_in),
        .in_o   (pin_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    // An access is taken only while no ack is pending, so a held request is not acked twice.
    assign sel  = mem_valid && ((mem_addr & WIN_MASK) == (ADDR & WIN_MASK));
    assign acc  = sel && !ready_q;
    assign wr   = acc && (mem_wstrb != 4'h0);
    assign off  = {mem_addr[5:2], 2'b00};
    assign wm   = WIDTH'(strb_mask(mem_wstrb));
    assign wd_m = WIDTH'(mem_wdata & strb_mask(mem_wstrb));
    assign evt  = (rise & ~edge_q) | (fall & edge_q);

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        en_d    = en_q;
        edge_d  = edge_q;
        clr     = '0;
        rdata_d = '0;
        if (acc) begin
            case (off)
                GIO_OUT:      rdata_d = 32'(out_q);
                GIO_DIR:      rdata_d = 32'(dir_q);
                GIO_IN:       rdata_d = 32'(pin_s);
                GIO_IRQ_EN:   rdata_d = 32'(en_q);
                GIO_IRQ_STAT: rdata_d = 32'(stat_q);
                GIO_EDGE:     rdata_d = 32'(edge_q);
                default:      rdata_d = '0;
            endcase
            if (wr) begin
                case (off)
                    GIO_OUT:      out_d  = (out_q & ~wm) | wd_m;
                    GIO_DIR:      dir_d  = (dir_q & ~wm) | wd_m;
                    GIO_IRQ_EN:   en_d   = (en_q & ~wm) | wd_m;
                    GIO_IRQ_STAT: clr    = wd_m;
                    GIO_EDGE:     edge_d = (edge_q & ~wm) | wd_m;
                    GIO_SET:      out_d  = out_q | wd_m;
                    GIO_CLR:      out_d  = out_q & ~wd_m;
                    GIO_TGL:      out_d  = out_q ^ wd_m;
                    default:      ;
                endcase
            end
        end
        // A new edge beats a concurrent write-1-to-clear on the same bit.
        stat_d = (stat_q & ~clr) | evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            stat_q  <= '0;
            edge_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            edge_q  <= edge_d;
            ready_q <= acc;
            rdata_q <= rdata_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign gpio_out  = out_q;
    assign gpio_oe   = dir_q;
    assign irq       = |(stat_q & en_q);

endmodule

// File: tb/tb_gio_bank.sv
// Self-checking bench for gio_bank: directed scenarios followed by a randomized
// sequence of bus accesses and pin changes checked against a register-level model.
module tb_gio_bank;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset, mem_valid, mem_ready, irq;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [7:0]  gpio_in, gpio_out, gpio_oe;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        rdy;

    logic [7:0] m_out, m_dir, m_en, m_stat, m_edge, m_pins;

    gio_bank #(.ADDR(BASE), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One access presented for a single cycle; returns what was seen in the ack cycle.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rdata, output logic ready);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        @(posedge clk);
        #1;
        ready     = mem_ready;
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic [5:0] off);
        case (off)
            6'h00:   return {24'h0, m_out};
            6'h04:   return {24'h0, m_dir};
            6'h08:   return {24'h0, m_pins};
            6'h0C:   return {24'h0, m_en};
            6'h10:   return {24'h0, m_stat};
            6'h14:   return {24'h0, m_edge};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [7:0] b;
        b = s[0] ? d[7:0] : 8'h00;
        case (off)
            6'h00: if (s[0]) m_out  = d[7:0];
            6'h04: if (s[0]) m_dir  = d[7:0];
            6'h0C: if (s[0]) m_en   = d[7:0];
            6'h10: m_stat = m_stat & ~b;
            6'h14: if (s[0]) m_edge = d[7:0];
            6'h18: m_out = m_out | b;
            6'h1C: m_out = m_out & ~b;
            6'h20: m_out = m_out ^ b;
            default: ;
        endcase
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        gpio_in = 8'h00;
        step(3);
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h want 00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
        reset = 1'b0;
        step(4);
    endtask

    task automatic test_basic_write;
        bus(BASE, 32'hAB, 4'hF, rd, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", rdy); end
        checks++; if (gpio_out !== 8'hAB) begin errors++; $display("FAIL wr_out: got %h want ab", gpio_out); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL wr_single_ack: got %b want 0", mem_ready); end
        bus(BASE, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'hAB) begin errors++; $display("FAIL rd_out: got %h want ab", rd); end
        bus(BASE + 32'h40, 32'h12, 4'hF, rd, rdy);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL unsel_ready: got %b want 0", rdy); end
        checks++; if (gpio_out !== 8'hAB) begin errors++; $display("FAIL unsel_out: got %h want ab", gpio_out); end
        bus(BASE + 32'h24, 32'hFF, 4'hF, rd, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL unmapped_ready: got %b want 1", rdy); end
        bus(BASE + 32'h24, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", rd); end
        bus(BASE + 32'h04, 32'h3C, 4'h2, rd, rdy);
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL dir_unstrobed: got %h want 00", gpio_oe); end
        bus(BASE + 32'h04, 32'h3C, 4'h1, rd, rdy);
        checks++; if (gpio_oe !== 8'h3C) begin errors++; $display("FAIL dir_strobed: got %h want 3c", gpio_oe); end
    endtask

    task automatic test_alias;
        bus(BASE + 32'h18, 32'h04, 4'hF, rd, rdy);
        checks++; if (gpio_out !== 8'hAF) begin errors++; $display("FAIL alias_set: got %h want af", gpio_out); end
        bus(BASE + 32'h1C, 32'h0F, 4'hF, rd, rdy);
        checks++; if (gpio_out !== 8'hA0) begin errors++; $display("FAIL alias_clr: got %h want a0", gpio_out); end
        bus(BASE + 32'h20, 32'hFF, 4'hF, rd, rdy);
        checks++; if (gpio_out !== 8'h5F) begin errors++; $display("FAIL alias_tgl: got %h want 5f", gpio_out); end
        bus(BASE + 32'h18, 32'hFF, 4'hE, rd, rdy);
        checks++; if (gpio_out !== 8'h5F) begin errors++; $display("FAIL alias_unstrobed: got %h want 5f", gpio_out); end
        for (int i = 0; i < 3; i++) begin
            bus(BASE + 32'h18 + 32'(4 * i), 32'h0, 4'h0, rd, rdy);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL alias_read%0d: got %h want 0", i, rd); end
        end
    endtask

    task automatic test_rise_irq;
        bus(BASE + 32'h04, 32'h00, 4'hF, rd, rdy);
        bus(BASE + 32'h14, 32'h00, 4'hF, rd, rdy);
        bus(BASE + 32'h10, 32'hFF, 4'hF, rd, rdy);
        bus(BASE + 32'h0C, 32'h01, 4'hF, rd, rdy);
        gpio_in = 8'h01;
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early: got %b want 0", irq); end
        step(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq); end
        bus(BASE + 32'h08, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL rise_in: got %h want 01", rd); end
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL rise_stat: got %h want 01", rd); end
        bus(BASE + 32'h10, 32'h01, 4'hF, rd, rdy);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_stat: got %h want 0", rd); end
    endtask

    task automatic test_fall_setwins;
        bus(BASE + 32'h14, 32'h02, 4'hF, rd, rdy);
        bus(BASE + 32'h0C, 32'h02, 4'hF, rd, rdy);
        gpio_in = 8'h03;
        step(4);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fall_ignores_rise: got %h want 0", rd); end
        gpio_in = 8'h01;
        step(3);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h02) begin errors++; $display("FAIL fall_stat: got %h want 02", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq: got %b want 1", irq); end
        bus(BASE + 32'h10, 32'h02, 4'hF, rd, rdy);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fall_w1c: got %h want 0", rd); end
        gpio_in = 8'h03;
        step(4);
        gpio_in = 8'h01;
        step(1);
        bus(BASE + 32'h10, 32'h02, 4'hF, rd, rdy);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h02) begin errors++; $display("FAIL set_wins: got %h want 02", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", irq); end
    endtask

    task automatic test_arm_midreset;
        gpio_in = 8'hFF;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(8);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL arm_stat: got %h want 0", rd); end
        bus(BASE + 32'h0C, 32'hFF, 4'hF, rd, rdy);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arm_irq: got %b want 0", irq); end
        reset = 1'b1;
        mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'h55; mem_wstrb = 4'hF;
        step(1);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", mem_ready); end
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL midreset_out: got %h want 00", gpio_out); end
        mem_valid = 1'b0; mem_wstrb = 4'h0; reset = 1'b0;
        step(1);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL midreset_late_ack: got %b want 0", mem_ready); end
        step(6);
    endtask

    task automatic test_random;
        logic [7:0]  nv, ev;
        logic [5:0]  off;
        logic [3:0]  s;
        logic [31:0] a, d, exp_rd;
        logic        in_win;
        m_out = 0; m_dir = 0; m_en = 0; m_stat = 0; m_edge = 0; m_pins = gpio_in;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                nv = 8'($urandom);
                ev = ((nv & ~m_pins) & ~m_edge) | ((~nv & m_pins) & m_edge);
                gpio_in = nv;
                step(4);
                m_stat = m_stat | ev;
                m_pins = nv;
            end else begin
                off    = {4'($urandom_range(0, 15)), 2'b00};
                s      = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                d      = $urandom;
                in_win = ($urandom_range(0, 7) != 0);
                a      = in_win ? (BASE | 32'(off)) : ((BASE ^ (32'h40 << $urandom_range(0, 25))) | 32'(off));
                exp_rd = m_read(off);
                bus(a, d, s, rd, rdy);
                checks++; if (rdy !== in_win) begin errors++; $display("FAIL rnd_ready[%0d] addr %h: got %b want %b", i, a, rdy, in_win); end
                if (in_win && s == 4'h0) begin
                    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d] off %h: got %h want %h", i, off, rd, exp_rd); end
                end
                if (in_win) m_write(off, d, s);
            end
            checks++; if (gpio_out !== m_out) begin errors++; $display("FAIL rnd_out[%0d]: got %h want %h", i, gpio_out, m_out); end
            checks++; if (gpio_oe !== m_dir) begin errors++; $display("FAIL rnd_oe[%0d]: got %h want %h", i, gpio_oe, m_dir); end
            checks++; if (irq !== |(m_stat & m_en)) begin errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq, |(m_stat & m_en)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_alias();
        test_rise_irq();
        test_fall_setwins();
        test_arm_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
